// File: rtl/n_to_1_mux.sv
// Parameterized N-to-1 word multiplexer with a combinational output and a registered copy.
// Out-of-range selects (possible only when N is not a power of two) yield zero and raise sel_err.
module n_to_1_mux #(
  parameter int width = 32,
  parameter int N     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [width-1:0]         d [0:N-1],
  input  logic [$clog2(N)-1:0]     sel,
  output logic [width-1:0]         m_out,
  output logic [width-1:0]         m_out_q,
  output logic                     sel_err,
  output logic                     sel_err_q
);

  localparam int          SW = $clog2(N);
  localparam int unsigned NU = N;

  // Decoded compare per input keeps the select tree free of out-of-range reads.
  always_comb begin
    m_out   = '0;
    sel_err = 1'b1;
    for (int unsigned i = 0; i < NU; i++) begin
      if (sel == SW'(i)) begin
        m_out   = d[i];
        sel_err = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      m_out_q   <= m_out;
      sel_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_n_to_1_mux.sv
// Scoreboard bench for n_to_1_mux: default 8x32, non-power-of-two 5x32 and minimal 2x1 instances.
module tb_n_to_1_mux;

  logic clk;
  logic rst_n;

  logic [31:0] d_a [0:7];
  logic [2:0]  sel_a;
  logic [31:0] m_out_a, m_out_q_a;
  logic        sel_err_a, sel_err_q_a;

  logic [31:0] d_b [0:4];
  logic [2:0]  sel_b;
  logic [31:0] m_out_b, m_out_q_b;
  logic        sel_err_b, sel_err_q_b;

  logic [0:0]  d_c [0:1];
  logic [0:0]  sel_c;
  logic [0:0]  m_out_c, m_out_q_c;
  logic        sel_err_c, sel_err_q_c;

  n_to_1_mux #(.width(32), .N(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .sel(sel_a),
    .m_out(m_out_a), .m_out_q(m_out_q_a), .sel_err(sel_err_a), .sel_err_q(sel_err_q_a)
  );

  n_to_1_mux #(.width(32), .N(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .sel(sel_b),
    .m_out(m_out_b), .m_out_q(m_out_q_b), .sel_err(sel_err_b), .sel_err_q(sel_err_q_b)
  );

  n_to_1_mux #(.width(1), .N(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .d(d_c), .sel(sel_c),
    .m_out(m_out_c), .m_out_q(m_out_q_c), .sel_err(sel_err_c), .sel_err_q(sel_err_q_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          id;
    logic [31:0] exp;
  } exp_t;

  exp_t sb [$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] probe(input int id);
    case (id)
      0:       probe = m_out_a;
      1:       probe = {31'd0, sel_err_a};
      2:       probe = m_out_q_a;
      3:       probe = {31'd0, sel_err_q_a};
      4:       probe = m_out_b;
      5:       probe = {31'd0, sel_err_b};
      6:       probe = m_out_q_b;
      7:       probe = {31'd0, sel_err_q_b};
      8:       probe = {31'd0, m_out_c};
      9:       probe = {31'd0, sel_err_c};
      default: probe = 'x;
    endcase
  endfunction

  // Monitor: drains every queued expectation when the stimulus signals a sample point.
  always begin
    @(sample_ev);
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = probe(e.id);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int id, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.id   = id;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  localparam logic [31:0] PAT [0:7] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD,
                                        32'hEEEE_EEEE, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) d_a[i] = PAT[i];
    d_b[0] = 32'h0000_0001; d_b[1] = 32'h0000_0010; d_b[2] = 32'h0000_0100;
    d_b[3] = 32'h0000_1000; d_b[4] = 32'h0001_0000;
    d_c[0] = 1'b1; d_c[1] = 1'b0;
    sel_a = '0; sel_b = '0; sel_c = '0;

    // Asynchronous reset well before the first clock edge
    #2 rst_n = 1'b0;
    #1;
    expect_val("a_reset_m_out_q", 2, 32'h0);
    expect_val("a_reset_sel_err_q", 3, 32'h0);
    expect_val("b_reset_m_out_q", 6, 32'h0);
    sample();

    // Select sweep, performed while reset is held to show the comb path ignores it
    for (int i = 0; i < 8; i++) begin
      sel_a = 3'(i);
      #1;
      expect_val($sformatf("a_sweep_m_out_sel%0d", i), 0, PAT[i]);
      expect_val($sformatf("a_sweep_sel_err_sel%0d", i), 1, 32'h0);
      sample();
    end

    sel_a = 3'd3;
    #1;
    d_a[3] = 32'h1234_5678;
    #1;
    expect_val("a_track_selected_d", 0, 32'h1234_5678);
    sample();
    d_a[5] = 32'h5555_0000;
    #1;
    expect_val("a_ignore_unselected_d", 0, 32'h1234_5678);
    sample();

    // Registered path
    @(negedge clk);
    rst_n = 1'b1;
    sel_a = 3'd6;
    @(posedge clk);
    #1;
    expect_val("a_q_after_release", 2, 32'h1111_1111);
    expect_val("a_err_q_after_release", 3, 32'h0);
    sample();
    sel_a = 3'd4;
    @(posedge clk);
    #1;
    expect_val("a_q_sel4", 2, 32'hEEEE_EEEE);
    sample();
    #2 rst_n = 1'b0;
    #1;
    expect_val("a_q_async_clear", 2, 32'h0);
    expect_val("a_comb_during_reset", 0, 32'hEEEE_EEEE);
    sample();
    @(posedge clk);
    #1;
    expect_val("a_q_held_in_reset", 2, 32'h0);
    sample();
    @(negedge clk);
    rst_n = 1'b1;

    // Non-power-of-two instance
    sel_b = 3'd4;
    #1;
    expect_val("b_sel4_m_out", 4, 32'h0001_0000);
    expect_val("b_sel4_sel_err", 5, 32'h0);
    sample();
    for (int i = 5; i < 8; i++) begin
      sel_b = 3'(i);
      #1;
      expect_val($sformatf("b_oor_m_out_sel%0d", i), 4, 32'h0);
      expect_val($sformatf("b_oor_sel_err_sel%0d", i), 5, 32'h1);
      sample();
    end
    @(posedge clk);
    #1;
    expect_val("b_sel_err_q", 7, 32'h1);
    expect_val("b_m_out_q_oor", 6, 32'h0);
    sample();

    // Minimal N=2, width=1 instance, two data patterns
    for (int p = 0; p < 2; p++) begin
      d_c[0] = p[0] ? 1'b0 : 1'b1;
      d_c[1] = p[0] ? 1'b1 : 1'b0;
      for (int s = 0; s < 2; s++) begin
        sel_c = s[0:0];
        #1;
        expect_val($sformatf("c_m_out_p%0d_sel%0d", p, s), 8, {31'd0, (s == 0) ^ (p == 1)});
        expect_val($sformatf("c_sel_err_p%0d_sel%0d", p, s), 9, 32'h0);
        sample();
      end
    end

    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n_to_1_mux.md
Name: n_to_1_mux

Overview:
Parameterized N-to-1 multiplexer. It selects one of N equal-width data words by a binary select index. The selected word is driven combinationally on m_out with zero latency. A registered copy of the selected word and an out-of-range select flag are also provided for timing-closed consumers. The block is a generic datapath building block, used wherever a bus-wide N-way selection is needed.

Parameters:
width, 32, bit width of each data word and of the outputs; legal range 1 or more.
N, 8, number of data inputs; legal range 2 or more; need not be a power of two.

Ports:
clk  input  1  clock; registered outputs only.
rst_n  input  1  asynchronous active-low reset.
d  input  unpacked array [0:N-1] of [width-1:0]  data inputs, index 0..N-1.
sel  input  [$clog2(N)-1:0]  binary select index.
m_out  output  [width-1:0]  combinational selected word.
m_out_q  output  [width-1:0]  registered selected word.
sel_err  output  1  combinational flag: sel is out of range (sel >= N).
sel_err_q  output  1  registered copy of sel_err.

Behaviour:
- Combinational path (m_out, sel_err):
  - m_out = d[sel] whenever sel < N. It is purely combinational: no clock dependency, and it updates within the same delta or propagation time as any change on sel or on the selected d word.
  - sel >= N is possible only when N is not a power of two. In that case m_out = 0 (all zeros) and sel_err = 1. Otherwise sel_err = 0.
  - X or Z on sel: m_out is not required to be defined.
  - Implementation requirement: no inferred latches. Every path assigns m_out, with a default of 0.
- Registered path (m_out_q, sel_err_q):
  - On the rising edge of clk: m_out_q <= m_out and sel_err_q <= sel_err. Latency is one cycle.
  - rst_n low: m_out_q = 0 and sel_err_q = 0 immediately, independent of clk. Both are held while rst_n is low.
  - On rst_n deassertion, the first rising clk edge loads the current selection.
- Reset behaviour:
  - Reset does not affect m_out or sel_err. They track inputs even during reset.
  - Reset asserted mid-operation clears the registered outputs asynchronously. The combinational outputs are unaffected.
- Simultaneous change of sel and d: m_out reflects the new d[new sel] after propagation. The register samples whatever is settled at the edge.
- Width rules:
  - No arithmetic; outputs are exactly width bits.
  - sel width is $clog2(N).

Test Plan:
- Defaults (width=32, N=8); d[0..7] = AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD, EEEE_EEEE, FFFF_FFFF, 1111_1111, 2222_2222. Sweep sel 0..7 with a 1 ns settle -> m_out equals d[sel] exactly (=== compare) and sel_err = 0.
- Hold sel=3 and change d[3] to 1234_5678 -> m_out = 1234_5678 within 1 ns. Change d[5] -> m_out unchanged.
- Registered path: rst_n=0 -> m_out_q = 0, sel_err_q = 0 with no clock. Release reset, set sel=6, apply a clk edge -> m_out_q = 1111_1111 one cycle later.
- Reset mid-operation: m_out_q = EEEE_EEEE, then assert rst_n low between edges -> m_out_q = 0 immediately. Meanwhile m_out still equals d[sel].
- Non-power-of-two, N=5 (sel is 3 bits): sel=4 -> d[4]. sel=5, 6, 7 -> m_out = 0 and sel_err = 1. After a clk edge, sel_err_q = 1.
- Corner N=2, width=1: sel toggles 0/1 -> m_out follows d[0]/d[1]; sel_err never asserts.
